add_seq: RTL and testbench

//  Parametrised multi-cycle adder: WIDTH-bit a + b + rin, computed CHUNK bits per cycle.

---
 rtl/add_pkg.sv | 22 ++
 rtl/add_chunk.sv | 27 ++
 rtl/add_fa.sv | 13 +
 rtl/add_seq.sv | 116 +++++++++++
 tb/tb_add_seq.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/add_pkg.sv
// Shared definitions for the sequential chunked adder: state encodings and
// a constant clog2 used to size the chunk index.
package add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple adder built from add_fa cells.
module add_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             rin,
  output logic [CHUNK-1:0] s,
  output logic             rout
);

  logic [CHUNK:0] c;

  assign c[0] = rin;
  assign rout = c[CHUNK];

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    add_fa u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .rin  (c[i]),
      .s    (s[i]),
      .rout (c[i+1])
    );
  end

endmodule

// File: rtl/add_fa.sv
// 1-bit full-adder cell, the building block of the chunk ripple adder.
module add_fa (
  input  logic a,
  input  logic b,
  input  logic rin,
  output logic s,
  output logic rout
);

  assign s    = a ^ b ^ rin;
  assign rout = (a & b) | (rin & (a ^ b));

endmodule

// File: rtl/add_seq.sv
// Multi-cycle WIDTH-bit adder, CHUNK bits per cycle with a registered carry.
// Optional signed-overflow output enabled by defining ADD_SEQ_OVF_EN.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding one chunk per cycle, idx selects the chunk
// DONE  | result valid, held until out_ready
module add_seq
  import add_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             rout
`ifdef ADD_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (clog2(N) > 1) ? clog2(N) : 1;

  state_t           state, state_n;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CHUNK-1:0] sum;
  logic             c_out;
  logic             last;

  assign last = (idx == IW'(N - 1));

  add_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_q[idx*CHUNK +: CHUNK]),
    .b    (b_q[idx*CHUNK +: CHUNK]),
    .rin  (carry),
    .s    (sum),
    .rout (c_out)
  );

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = RUN;
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      s     <= '0;
      rout  <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= rin;
            idx   <= '0;
          end
        end
        RUN: begin
          s[idx*CHUNK +: CHUNK] <= sum;
          carry                 <= c_out;
          if (last) begin
            rout <= c_out;
`ifdef ADD_SEQ_OVF_EN
            // sum[CHUNK-1] is the final s[WIDTH-1] on the last step
            ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[CHUNK-1] != a_q[WIDTH-1]);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq.sv
// Bench for add_seq: directed cases on a CHUNK=8 instance plus random
// operands on CHUNK=8/32/1 instances checked against plain arithmetic.
module tb_add_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic rin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, rin};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic rin);
    longint sa;
    sa = longint'($signed(a)) + longint'($signed(b)) + longint'(rin);
    return (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
  endfunction

  // ---------------- directed instance ----------------
  logic         m_rst = 1'b1;
  logic         m_iv = 1'b0, m_ir, m_ov, m_or = 1'b0, m_rin = 1'b0, m_rout;
  logic [W-1:0] m_a = '0, m_b = '0, m_s;
  logic         m_ovf;

  add_seq #(.WIDTH(W), .CHUNK(8)) u_main (
    .clk       (clk),
    .rst       (m_rst),
    .in_valid  (m_iv),
    .in_ready  (m_ir),
    .a         (m_a),
    .b         (m_b),
    .rin       (m_rin),
    .out_valid (m_ov),
    .out_ready (m_or),
    .s         (m_s),
    .rout      (m_rout)
`ifdef ADD_SEQ_OVF_EN
    ,
    .ovf       (m_ovf)
`endif
  );
`ifndef ADD_SEQ_OVF_EN
  assign m_ovf = 1'b0;
`endif

  // Accept one operation and wait for out_valid; inputs are scrambled while running.
  task automatic m_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic rin,
                      output int lat);
    int guard;
    m_a = a; m_b = b; m_rin = rin; m_iv = 1'b1; m_or = 1'b0;
    guard = 0;
    while (!m_ir && guard < 100) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    m_iv = 1'b0; m_a = $urandom; m_b = $urandom; m_rin = 1'($urandom);
    lat = 0;
    while (!m_ov && lat < 100) begin
      @(posedge clk); #1; lat++;
      m_a = $urandom; m_b = $urandom;
    end
  endtask

  task automatic m_drain();
    m_or = 1'b1;
    @(posedge clk); #1;
    m_or = 1'b0;
  endtask

  // ---------------- random instances ----------------
  logic       r_rst = 1'b1;
  logic [2:0] done = '0;

  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int CH = (g == 0) ? 8 : ((g == 1) ? 32 : 1);
    localparam int NS = W / CH;
    logic         iv = 1'b0, ir, ov, orr = 1'b0, rin = 1'b0, rout_o, ovf_o;
    logic [W-1:0] a = '0, b = '0, s;

    add_seq #(.WIDTH(W), .CHUNK(CH)) u_dut (
      .clk       (clk),
      .rst       (r_rst),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (a),
      .b         (b),
      .rin       (rin),
      .out_valid (ov),
      .out_ready (orr),
      .s         (s),
      .rout      (rout_o)
`ifdef ADD_SEQ_OVF_EN
      ,
      .ovf       (ovf_o)
`endif
    );
`ifndef ADD_SEQ_OVF_EN
    assign ovf_o = 1'b0;
`endif

    initial begin
      logic [W-1:0] ta, tb;
      logic         tr;
      int           lat, guard;
      wait (r_rst == 1'b0);
      @(posedge clk); #1;
      for (int k = 0; k < 1000; k++) begin
        ta = $urandom; tb = $urandom; tr = 1'($urandom);
        if (k % 7 == 0) ta = '1;
        a = ta; b = tb; rin = tr; iv = 1'b1;
        guard = 0;
        while (!ir && guard < 100) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        iv = 1'b0; a = $urandom; b = $urandom; rin = 1'($urandom);
        lat = 0;
        while (!ov && lat < 100) begin @(posedge clk); #1; lat++; a = $urandom; end
        chk("rnd_lat", 64'(lat), 64'(NS));
        chk("rnd_sum", 64'({rout_o, s}), 64'(ref_sum(ta, tb, tr)));
`ifdef ADD_SEQ_OVF_EN
        chk("rnd_ovf", 64'(ovf_o), 64'(ref_ovf(ta, tb, tr)));
`endif
        guard = 0;
        do begin
          orr = 1'($urandom_range(0, 1));
          @(posedge clk); #1; guard++;
        end while (ov && guard < 100);
        orr = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      done[g] = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int           lat, cyc;
    logic [W-1:0] s0;
    logic         r0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(m_ir),   64'd1);
    chk("rst_out_valid", 64'(m_ov),   64'd0);
    chk("rst_s",         64'(m_s),    64'd0);
    chk("rst_rout",      64'(m_rout), 64'd0);
    m_rst = 1'b0; r_rst = 1'b0;
    @(posedge clk); #1;

    m_op(32'hFFFFFFFF, 32'h1, 1'b0, lat);
    chk("t1_lat",  64'(lat),    64'd4);
    chk("t1_s",    64'(m_s),    64'h0);
    chk("t1_rout", 64'(m_rout), 64'd1);
    chk("t1_ir",   64'(m_ir),   64'd0);
    m_drain();

    m_op(32'h0, 32'h0, 1'b1, lat);
    chk("t2a_s",    64'(m_s),    64'h1);
    chk("t2a_rout", 64'(m_rout), 64'd0);
    m_drain();
    m_op(32'h12345678, 32'h9ABCDEF0, 1'b0, lat);
    chk("t2b_s",    64'(m_s),    64'hACF13568);
    chk("t2b_rout", 64'(m_rout), 64'd0);

    // hold the result with out_ready low while pulsing in_valid
    s0 = m_s; r0 = m_rout;
    for (int i = 0; i < 5; i++) begin
      m_iv = 1'b1; m_a = $urandom; m_b = $urandom;
      @(posedge clk); #1;
      chk("t3_s",  64'({m_rout, m_s, m_ir, m_ov}), 64'({r0, s0, 1'b0, 1'b1}));
    end
    m_iv = 1'b0;
    m_drain();
    chk("t3_ir_after", 64'(m_ir), 64'd1);
    chk("t3_ov_after", 64'(m_ov), 64'd0);

    // reset during the second RUN cycle
    m_a = 32'hDEADBEEF; m_b = 32'h11111111; m_rin = 1'b1; m_iv = 1'b1;
    @(posedge clk); #1;
    m_iv = 1'b0;
    @(posedge clk); #1;
    m_rst = 1'b1;
    #1;
    chk("t4_ov",   64'(m_ov),   64'd0);
    chk("t4_s",    64'(m_s),    64'd0);
    chk("t4_rout", 64'(m_rout), 64'd0);
    chk("t4_ir",   64'(m_ir),   64'd1);
    @(posedge clk); #1;
    m_rst = 1'b0;
    @(posedge clk); #1;
    m_op(32'hDEADBEEF, 32'h11111111, 1'b1, lat);
    chk("t4_lat", 64'(lat), 64'd4);
    chk("t4_sum", 64'({m_rout, m_s}), 64'(ref_sum(32'hDEADBEEF, 32'h11111111, 1'b1)));
    m_drain();

`ifdef ADD_SEQ_OVF_EN
    m_op(32'h7FFFFFFF, 32'h1, 1'b0, lat);
    chk("t5a_ovf", 64'(m_ovf), 64'd1);
    chk("t5a_s",   64'(m_s),   64'h80000000);
    m_drain();
    m_op(32'hFFFFFFFF, 32'h1, 1'b0, lat);
    chk("t5b_ovf",  64'(m_ovf),  64'd0);
    chk("t5b_rout", 64'(m_rout), 64'd1);
    m_drain();
`endif

    cyc = 0;
    while (done != 3'b111 && cyc < 80000) begin @(posedge clk); cyc++; end
    chk("rnd_done", 64'(done), 64'h7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
